q_mult: RTL and testbench

Signed fixed-point multiplier used per input channel inside the pointwise-convolution unit. It multiplies one N-bit activation by one N-bit weight and returns the full-precision product, sign-extended to 32 bits. It also raises a valid flag aligned to each product and a one-cycle end-of-burst flag. Scaling is not done here: the downstream accumulator adds bias, right-shifts, and applies ReLU.

---
 rtl/q_mult_pkg.sv | 10 +
 rtl/q_mult.sv | 71 +++++++
 tb/tb_q_mult.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/q_mult_pkg.sv
// Shared fixed-point constants for the pointwise-convolution datapath.
// Parents use QMULT_LAT to align bias and shift pipelines with q_mult products.
package q_mult_pkg;

    localparam int unsigned ACC_W      = 32;
    localparam int unsigned QMULT_LAT  = 2;
    localparam int unsigned QMULT_NMIN = 2;
    localparam int unsigned QMULT_NMAX = 16;

endpackage

// File: rtl/q_mult.sv
// Signed N x N multiplier with a two-stage pipeline, full-precision result sign-extended to ACC_W,
// an aligned valid flag and a one-cycle end-of-burst pulse on the falling edge of output valid.
module q_mult
    import q_mult_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             input_vld,
    input  logic [N-1:0]     multiplicand_din,
    input  logic [N-1:0]     multiplier_din,
    output logic [ACC_W-1:0] product_dout,
    output logic             product_dout_vld,
    output logic             product_end
);

    if (N < QMULT_NMIN || N > QMULT_NMAX) begin : g_bad_n
        $error("q_mult: N must lie in 2..16");
    end

    logic [N-1:0]            a_q, a_d;
    logic [N-1:0]            b_q, b_d;
    logic                    vld1_q;
    logic [ACC_W-1:0]        prod_q, prod_d;
    logic                    vld2_q;
    logic                    end_q, end_d;
    logic signed [ACC_W-1:0] a_ext, b_ext, prod;

    // 2N <= ACC_W, so the product of the sign-extended operands is exact in ACC_W bits.
    assign a_ext = ACC_W'($signed(a_q));
    assign b_ext = ACC_W'($signed(b_q));
    assign prod  = a_ext * b_ext;

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        prod_d = '0;
        end_d  = vld2_q & ~vld1_q;
        if (input_vld) begin
            a_d = multiplicand_din;
            b_d = multiplier_din;
        end
        if (vld1_q) begin
            prod_d = prod;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            vld1_q <= 1'b0;
            prod_q <= '0;
            vld2_q <= 1'b0;
            end_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            vld1_q <= input_vld;
            prod_q <= prod_d;
            vld2_q <= vld1_q;
            end_q  <= end_d;
        end
    end

    assign product_dout     = prod_q;
    assign product_dout_vld = vld2_q;
    assign product_end      = end_q;

endmodule

// File: tb/tb_q_mult.sv
// Directed and random checks of q_mult at N=16 and N=8, both instances sharing input_vld.
module tb_q_mult;
    import q_mult_pkg::*;

    localparam int R = 10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        input_vld;
    logic [15:0] a16, b16;
    logic [7:0]  a8, b8;
    logic [31:0] d16, d8;
    logic        v16, v8, e16, e8;

    int n_total = 0;
    int n_pass  = 0;

    bit          rv [R+2];
    logic [31:0] rp16 [R+2];
    logic [31:0] rp8 [R+2];

    always #5 clk = ~clk;

    q_mult #(.N(16)) dut16 (
        .clk              (clk),
        .rst_n            (rst_n),
        .input_vld        (input_vld),
        .multiplicand_din (a16),
        .multiplier_din   (b16),
        .product_dout     (d16),
        .product_dout_vld (v16),
        .product_end      (e16)
    );

    q_mult #(.N(8)) dut8 (
        .clk              (clk),
        .rst_n            (rst_n),
        .input_vld        (input_vld),
        .multiplicand_din (a8),
        .multiplier_din   (b8),
        .product_dout     (d8),
        .product_dout_vld (v8),
        .product_end      (e8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic [31:0] x16, input logic [31:0] x8,
                             input logic v, input logic e);
        check({tag, "/d16"}, d16, x16);
        check({tag, "/v16"}, {31'b0, v16}, {31'b0, v});
        check({tag, "/e16"}, {31'b0, e16}, {31'b0, e});
        check({tag, "/d8"}, d8, x8);
        check({tag, "/v8"}, {31'b0, v8}, {31'b0, v});
        check({tag, "/e8"}, {31'b0, e8}, {31'b0, e});
    endtask

    task automatic drive(input logic v, input logic [15:0] x16, input logic [15:0] y16,
                         input logic [7:0] x8, input logic [7:0] y8);
        input_vld = v;
        a16 = x16;
        b16 = y16;
        a8  = x8;
        b8  = y8;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        longint p;
        logic   v;
        logic [15:0] x16, y16;
        logic [7:0]  x8, y8;

        // Reset held with valid inputs present: nothing may come out.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
            tick();
            check_out("reset", 32'h0, 32'h0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 8'h0, 8'h0);
        tick();
        check_out("post_reset0", 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check_out("post_reset1", 32'h0, 32'h0, 1'b0, 1'b0);

        // Single product 3 x -4.
        drive(1'b1, 16'd3, 16'hFFFC, 8'd3, 8'hFC);
        tick();
        check_out("single_lat1", 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 8'h0, 8'h0);
        tick();
        check_out("single_out", 32'hFFFF_FFF4, 32'hFFFF_FFF4, 1'b1, 1'b0);
        tick();
        check_out("single_end", 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        check_out("single_idle", 32'h0, 32'h0, 1'b0, 1'b0);

        // Extremes burst of four.
        drive(1'b1, 16'h8000, 16'h8000, 8'h80, 8'h80);
        tick();
        check_out("ext_lat1", 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 16'h7FFF, 16'h7FFF, 8'h7F, 8'h7F);
        tick();
        check_out("ext_minmin", 32'h4000_0000, 32'h0000_4000, 1'b1, 1'b0);
        drive(1'b1, 16'h8000, 16'h7FFF, 8'h80, 8'h7F);
        tick();
        check_out("ext_maxmax", 32'h3FFF_0001, 32'h0000_3F01, 1'b1, 1'b0);
        drive(1'b1, 16'h0000, 16'h1234, 8'h00, 8'h12);
        tick();
        check_out("ext_minmax", 32'hC000_8000, 32'hFFFF_C080, 1'b1, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 8'h0, 8'h0);
        tick();
        check_out("ext_zero", 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        check_out("ext_end", 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        check_out("ext_idle", 32'h0, 32'h0, 1'b0, 1'b0);

        // Gapped stream 1,1,0,1; operand 9x9 during the gap must be ignored.
        drive(1'b1, 16'd1, 16'd1, 8'd1, 8'd1);
        tick();
        check_out("gap_lat1", 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 16'd2, 16'd2, 8'd2, 8'd2);
        tick();
        check_out("gap_p1", 32'd1, 32'd1, 1'b1, 1'b0);
        drive(1'b0, 16'd9, 16'd9, 8'd9, 8'd9);
        tick();
        check_out("gap_p4", 32'd4, 32'd4, 1'b1, 1'b0);
        drive(1'b1, 16'd5, 16'd5, 8'd5, 8'd5);
        tick();
        check_out("gap_end", 32'h0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 16'h0, 16'h0, 8'h0, 8'h0);
        tick();
        check_out("gap_p25", 32'd25, 32'd25, 1'b1, 1'b0);
        tick();
        check_out("gap_final_end", 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        check_out("gap_idle", 32'h0, 32'h0, 1'b0, 1'b0);

        // Reset while two products are in flight.
        drive(1'b1, 16'd7, 16'd9, 8'd7, 8'd9);
        tick();
        check_out("mid_lat1", 32'h0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 16'd11, 16'd13, 8'd11, 8'd13);
        rst_n = 1'b0;
        tick();
        check_out("mid_rst", 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 8'h0, 8'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("mid_after", 32'h0, 32'h0, 1'b0, 1'b0);
        end

        // Random regression against a cycle-shifted reference.
        rv[0] = 1'b0;
        rv[1] = 1'b0;
        rp16[0] = '0;
        rp16[1] = '0;
        rp8[0]  = '0;
        rp8[1]  = '0;
        for (int t = 0; t < R; t++) begin
            v   = ($urandom_range(0, 3) != 0);
            x16 = 16'($urandom);
            y16 = 16'($urandom);
            x8  = 8'($urandom);
            y8  = 8'($urandom);
            rv[t+2] = v;
            p = longint'($signed(x16)) * longint'($signed(y16));
            rp16[t+2] = v ? p[31:0] : 32'h0;
            p = longint'($signed(x8)) * longint'($signed(y8));
            rp8[t+2] = v ? p[31:0] : 32'h0;
            drive(v, x16, y16, x8, y8);
            tick();
            check_out("rand", rp16[t+1], rp8[t+1], rv[t+1], !rv[t+1] && rv[t]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
